// File: rtl/niosii_led_pio_out.sv
// Avalon-MM output PIO: DATA with atomic set/clear, plus a self-timed pulse mask on a shared counter.
// Optional readback of DATA/PULSE_STATUS when NIOSII_LED_PIO_READBACK_EN is defined.
module niosii_led_pio_out #(
   parameter int               WIDTH        = 4,
   parameter int               PULSE_CYCLES = 1000,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam int            CW       = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

   typedef struct packed {
      logic             wr;
      logic [2:0]       addr;
      logic [WIDTH-1:0] wd;
   } req_t;

   req_t             req;
   logic             unused_wd;
   logic             pulse_wr;
   logic [WIDTH-1:0] data, next_data;
   logic [WIDTH-1:0] mask, next_mask;
   logic [CW-1:0]    cnt, next_cnt;

   assign req.wr    = chipselect & ~write_n;
   assign req.addr  = address;
   assign req.wd    = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;
   assign pulse_wr  = req.wr && (req.addr == 3'd2) && (req.wd != '0);

   always_comb begin
      next_data = data;
      if (req.wr) begin
         case (req.addr)
            3'd0:    next_data = req.wd;
            3'd4:    next_data = data | req.wd;
            3'd5:    next_data = data & ~req.wd;
            default: next_data = data;
         endcase
      end
   end

   // A pulse write takes priority over expiry, so a retrigger in the last cycle never glitches low.
   always_comb begin
      next_mask = mask;
      next_cnt  = cnt;
      if (pulse_wr) begin
         next_mask = mask | req.wd;
         next_cnt  = CNT_LOAD;
      end else if (mask != '0) begin
         if (cnt != '0) next_cnt  = cnt - CW'(1);
         else           next_mask = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data     <= RESET_VALUE;
         mask     <= '0;
         cnt      <= '0;
         out_port <= RESET_VALUE;
      end else begin
         data     <= next_data;
         mask     <= next_mask;
         cnt      <= next_cnt;
         out_port <= next_data | next_mask;
      end
   end

`ifdef NIOSII_LED_PIO_READBACK_EN
   // Sampled every cycle regardless of strobe; returns pre-edge register contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            3'd0:    readdata <= 32'(data);
            3'd3:    readdata <= 32'(mask);
            default: readdata <= '0;
         endcase
      end
   end
`else
   assign readdata = '0;
`endif

endmodule
